// File: rtl/sort_rd_dma.sv
// AXI read DMA feeding a sort kernel: fetches i_total_beats 64-byte beats into a credit-gated FWFT FIFO.
// Optional job cycle counter on o_perf_cycles is enabled by defining SORT_RD_DMA_PERF_CNT_EN.
module sort_rd_dma #(
    parameter int C_M_AXI_HOST_MEM_ID_WIDTH   = 5,
    parameter int C_M_AXI_HOST_MEM_ADDR_WIDTH = 64,
    parameter int C_M_AXI_HOST_MEM_DATA_WIDTH = 512,
    parameter int FIFO_DEPTH                  = 128
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_start,
    input  logic [C_M_AXI_HOST_MEM_ADDR_WIDTH-1:0] i_src_addr,
    input  logic [31:0]                            i_total_beats,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_error,
    output logic [31:0]                            o_perf_cycles,
    output logic [C_M_AXI_HOST_MEM_ID_WIDTH-1:0]   m_axi_snap_arid,
    output logic [C_M_AXI_HOST_MEM_ADDR_WIDTH-1:0] m_axi_snap_araddr,
    output logic [7:0]                             m_axi_snap_arlen,
    output logic [2:0]                             m_axi_snap_arsize,
    output logic [1:0]                             m_axi_snap_arburst,
    output logic                                   m_axi_snap_arvalid,
    input  logic                                   m_axi_snap_arready,
    output logic                                   m_axi_snap_rready,
    input  logic [C_M_AXI_HOST_MEM_ID_WIDTH-1:0]   m_axi_snap_rid,
    input  logic [C_M_AXI_HOST_MEM_DATA_WIDTH-1:0] m_axi_snap_rdata,
    input  logic [1:0]                             m_axi_snap_rresp,
    input  logic                                   m_axi_snap_rlast,
    input  logic                                   m_axi_snap_rvalid,
    output logic [C_M_AXI_HOST_MEM_DATA_WIDTH-1:0] o_data,
    output logic                                   o_valid,
    input  logic                                   i_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = PW + 1;
    localparam int AW = C_M_AXI_HOST_MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                                   r_state;
    state_t                                   w_state_next;
    logic [AW-1:0]                            r_addr;
    logic [31:0]                              r_remain;
    logic [RW-1:0]                            r_reserved;
    logic                                     r_error;
    logic [C_M_AXI_HOST_MEM_DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [PW:0]                              r_wr_ptr;
    logic [PW:0]                              r_rd_ptr;

    logic [6:0]    w_room;
    logic [6:0]    w_len;
    logic          w_credit_ok;
    logic          w_start;
    logic          w_ar_hs;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [RW-1:0] w_res_inc;
    logic [RW-1:0] w_res_dec;

    // Burst never crosses a 4KB page: room is the beats left in the current page.
    assign w_room      = 7'd64 - {1'b0, r_addr[11:6]};
    assign w_len       = (r_remain < {25'd0, w_room}) ? r_remain[6:0] : w_room;
    assign w_credit_ok = ({{(32-RW){1'b0}}, r_reserved} + {25'd0, w_len}) <= 32'(FIFO_DEPTH);
    assign w_start     = (r_state == S_IDLE) && i_start;
    assign w_ar_hs     = m_axi_snap_arvalid && m_axi_snap_arready;
    assign w_push      = m_axi_snap_rvalid && m_axi_snap_rready;
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_pop       = o_valid && i_ready;
    assign w_res_inc   = w_ar_hs ? RW'(w_len) : '0;
    assign w_res_dec   = {{(RW-1){1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_ISSUE;
            S_ISSUE: begin
                // A zero-length job has nothing to issue or drain.
                if (r_remain == 32'd0) begin
                    w_state_next = S_DONE;
                end else if (w_ar_hs && ({25'd0, w_len} == r_remain)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: if (w_pop && (r_reserved == RW'(1))) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy             = (r_state != S_IDLE);
        o_done             = (r_state == S_DONE);
        m_axi_snap_arvalid = (r_state == S_ISSUE) && (r_remain != 32'd0) && w_credit_ok;
        m_axi_snap_rready  = (r_state != S_IDLE);
    end

    assign m_axi_snap_arid    = '0;
    assign m_axi_snap_araddr  = r_addr;
    assign m_axi_snap_arlen   = (r_remain == 32'd0) ? 8'd0 : ({1'b0, w_len} - 8'd1);
    assign m_axi_snap_arsize  = 3'b110;
    assign m_axi_snap_arburst = 2'b01;
    assign o_error            = r_error;
    assign o_valid            = !w_empty;
    assign o_data             = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_remain   <= '0;
            r_reserved <= '0;
            r_error    <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_start) begin
                r_addr   <= i_src_addr;
                r_remain <= i_total_beats;
            end else if (w_ar_hs) begin
                r_addr   <= r_addr + {{(AW-13){1'b0}}, w_len, 6'b0};
                r_remain <= r_remain - {25'd0, w_len};
            end
            r_reserved <= r_reserved + w_res_inc - w_res_dec;
            if (w_start) begin
                r_error <= 1'b0;
            end else if (w_push && (m_axi_snap_rresp != 2'b00)) begin
                r_error <= 1'b1;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Credit guarantees space, so writes never check for full.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= m_axi_snap_rdata;
        end
    end

`ifdef SORT_RD_DMA_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_start) begin
            r_perf <= '0;
        end else if (o_busy) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign o_perf_cycles = r_perf;
`else
    assign o_perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_sort_rd_dma.sv
// Randomized bench for sort_rd_dma: reactive AXI read slave plus a spec-level burst/data model.
module tb_sort_rd_dma;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [63:0]   i_src_addr;
    logic [31:0]   i_total_beats;
    logic          o_busy, o_done, o_error;
    logic [31:0]   o_perf_cycles;
    logic [4:0]    arid;
    logic [63:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid, arready, rready;
    logic [4:0]    rid;
    logic [511:0]  rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid;
    logic [511:0]  o_data;
    logic          o_valid, i_ready;

    always #5 clk = ~clk;

    sort_rd_dma dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_src_addr(i_src_addr),
        .i_total_beats(i_total_beats), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_perf_cycles(o_perf_cycles), .m_axi_snap_arid(arid), .m_axi_snap_araddr(araddr),
        .m_axi_snap_arlen(arlen), .m_axi_snap_arsize(arsize), .m_axi_snap_arburst(arburst),
        .m_axi_snap_arvalid(arvalid), .m_axi_snap_arready(arready), .m_axi_snap_rready(rready),
        .m_axi_snap_rid(rid), .m_axi_snap_rdata(rdata), .m_axi_snap_rresp(rresp),
        .m_axi_snap_rlast(rlast), .m_axi_snap_rvalid(rvalid),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] salt;

    // observation logs filled by run_job
    logic [63:0]  ar_addr_q[$];
    int           ar_len_q[$];
    logic [511:0] out_q[$];
    logic [63:0]  sl_addr_q[$];
    logic         sl_last_q[$];
    int busy_cycles, done_cnt, done_k, first_av_k, max_res, issued, popped, issued_at_hold;
    bit timeout;
    logic err_k1, err_after;
    logic [31:0] perf_after;

    // reference model: bursts derived from the 4KB page rule
    logic [63:0] exp_addr_q[$];
    int          exp_len_q[$];

    function automatic logic [511:0] mk_data(input logic [63:0] a);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = a[31:0] ^ salt ^ 32'(i * 32'h0101_0101);
        return d;
    endfunction

    task automatic build_exp(input logic [63:0] a0, input int beats);
        int rem, room, len;
        logic [63:0] a;
        exp_addr_q.delete();
        exp_len_q.delete();
        rem = beats;
        a = a0;
        while (rem > 0) begin
            room = 64 - int'(a[11:6]);
            len = (rem < room) ? rem : room;
            exp_addr_q.push_back(a);
            exp_len_q.push_back(len);
            a = a + 64'(64 * len);
            rem = rem - len;
        end
    endtask

    task automatic run_job(input logic [63:0] addr, input int beats, input int err_idx,
                           input int ar_pct, input int r_pct, input int rdy_pct,
                           input int hold, input bit dbl_start);
        int k, idx;
        logic [63:0] a;
        ar_addr_q.delete(); ar_len_q.delete(); out_q.delete();
        sl_addr_q.delete(); sl_last_q.delete();
        busy_cycles = 0; done_cnt = 0; done_k = -1; first_av_k = -1;
        max_res = 0; issued = 0; popped = 0; issued_at_hold = 0; timeout = 0;
        @(negedge clk);
        i_start = 1'b1; i_src_addr = addr; i_total_beats = 32'(beats);
        k = 0;
        while (1) begin
            @(negedge clk);
            k++;
            if (dbl_start && k == 1) begin
                i_start = 1'b1; i_src_addr = addr + 64'h4000; i_total_beats = 32'd5;
            end else begin
                i_start = 1'b0;
            end
            if (k == 1) err_k1 = o_error;
            arready = ($urandom_range(99) < 32'(ar_pct));
            i_ready = (k <= hold) ? 1'b0 : ($urandom_range(99) < 32'(rdy_pct));
            if (sl_addr_q.size() > 0 && $urandom_range(99) < 32'(r_pct)) begin
                a = sl_addr_q[0];
                idx = int'((a - addr) >> 6);
                rvalid = 1'b1;
                rdata = mk_data(a);
                rresp = (idx == err_idx) ? 2'b10 : 2'b00;
                rlast = sl_last_q[0];
                if (rready) begin
                    void'(sl_addr_q.pop_front());
                    void'(sl_last_q.pop_front());
                end
            end else begin
                rvalid = 1'b0;
            end
            if (arvalid && first_av_k < 0) first_av_k = k;
            if (arvalid && arready) begin
                ar_addr_q.push_back(araddr);
                ar_len_q.push_back(int'(arlen));
                for (int j = 0; j <= int'(arlen); j++) begin
                    sl_addr_q.push_back(araddr + 64'(64 * j));
                    sl_last_q.push_back(j == int'(arlen));
                end
                issued += int'(arlen) + 1;
            end
            if (o_valid && i_ready) begin
                out_q.push_back(o_data);
                popped++;
            end
            if (issued - popped > max_res) max_res = issued - popped;
            if (k <= hold) issued_at_hold = issued;
            if (o_busy) busy_cycles++;
            if (o_done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k > done_k + 2) break;
            if (k > 20000) begin
                timeout = 1'b1;
                break;
            end
        end
        i_start = 1'b0; arready = 1'b0; rvalid = 1'b0; i_ready = 1'b0;
        err_after = o_error;
        perf_after = o_perf_cycles;
        $display("job addr=%h beats=%0d ars=%0d outs=%0d done_k=%0d busy=%0d", addr, beats,
                 ar_addr_q.size(), out_q.size(), done_k, busy_cycles);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 8;
        if (arvalid !== 1'b0)       begin n_fail++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
        if (o_valid !== 1'b0)       begin n_fail++; $display("FAIL rst_o_valid got=%b exp=0", o_valid); end
        if (o_busy !== 1'b0)        begin n_fail++; $display("FAIL rst_o_busy got=%b exp=0", o_busy); end
        if (o_done !== 1'b0)        begin n_fail++; $display("FAIL rst_o_done got=%b exp=0", o_done); end
        if (o_error !== 1'b0)       begin n_fail++; $display("FAIL rst_o_error got=%b exp=0", o_error); end
        if (o_perf_cycles !== 32'd0) begin n_fail++; $display("FAIL rst_perf got=%0d exp=0", o_perf_cycles); end
        if (araddr !== 64'd0)       begin n_fail++; $display("FAIL rst_araddr got=%h exp=0", araddr); end
        if (arlen !== 8'd0)         begin n_fail++; $display("FAIL rst_arlen got=%0d exp=0", arlen); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        run_job(64'h1000, 16, -1, 100, 100, 100, 0, 1'b0);
        n_cmp += 6;
        if (timeout)               begin n_fail++; $display("FAIL single_timeout got=1 exp=0"); end
        if (ar_addr_q.size() != 1) begin n_fail++; $display("FAIL single_ar_count got=%0d exp=1", ar_addr_q.size()); end
        else begin
            if (ar_len_q[0] != 15)        begin n_fail++; $display("FAIL single_arlen got=%0d exp=15", ar_len_q[0]); end
            if (ar_addr_q[0] !== 64'h1000) begin n_fail++; $display("FAIL single_araddr got=%h exp=1000", ar_addr_q[0]); end
        end
        if (done_cnt != 1)   begin n_fail++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
        if (first_av_k != 1) begin n_fail++; $display("FAIL single_first_arvalid got=%0d exp=1", first_av_k); end
        n_cmp++;
        if (out_q.size() != 16) begin n_fail++; $display("FAIL single_out_count got=%0d exp=16", out_q.size()); end
        else for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (out_q[i] !== mk_data(64'h1000 + 64'(64 * i)))
                begin n_fail++; $display("FAIL single_data[%0d] got=%h exp=%h", i, out_q[i], mk_data(64'h1000 + 64'(64 * i))); end
        end
    endtask

    task automatic test_boundary();
        run_job(64'h1F80, 10, -1, 60, 80, 90, 0, 1'b0);
        n_cmp += 2;
        if (timeout) begin n_fail++; $display("FAIL bound_timeout got=1 exp=0"); end
        if (ar_addr_q.size() != 2) begin n_fail++; $display("FAIL bound_ar_count got=%0d exp=2", ar_addr_q.size()); end
        else begin
            n_cmp += 4;
            if (ar_addr_q[0] !== 64'h1F80) begin n_fail++; $display("FAIL bound_ar0_addr got=%h exp=1f80", ar_addr_q[0]); end
            if (ar_len_q[0] != 1)          begin n_fail++; $display("FAIL bound_ar0_len got=%0d exp=1", ar_len_q[0]); end
            if (ar_addr_q[1] !== 64'h2000) begin n_fail++; $display("FAIL bound_ar1_addr got=%h exp=2000", ar_addr_q[1]); end
            if (ar_len_q[1] != 7)          begin n_fail++; $display("FAIL bound_ar1_len got=%0d exp=7", ar_len_q[1]); end
        end
    endtask

    task automatic test_backpressure();
        run_job(64'h1000, 300, -1, 100, 100, 70, 400, 1'b0);
        n_cmp += 5;
        if (timeout)               begin n_fail++; $display("FAIL bp_timeout got=1 exp=0"); end
        if (issued_at_hold != 128) begin n_fail++; $display("FAIL bp_issued_held got=%0d exp=128", issued_at_hold); end
        if (max_res > 128)         begin n_fail++; $display("FAIL bp_max_reserved got=%0d exp<=128", max_res); end
        if (done_cnt != 1)         begin n_fail++; $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt); end
        if (out_q.size() != 300)   begin n_fail++; $display("FAIL bp_out_count got=%0d exp=300", out_q.size()); end
        else for (int i = 0; i < 300; i++) begin
            n_cmp++;
            if (out_q[i] !== mk_data(64'h1000 + 64'(64 * i)))
                begin n_fail++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, out_q[i], mk_data(64'h1000 + 64'(64 * i))); end
        end
    endtask

    task automatic test_zero_beats();
        run_job(64'h8000, 0, -1, 100, 100, 100, 0, 1'b1);
        n_cmp += 6;
        if (timeout)               begin n_fail++; $display("FAIL zero_timeout got=1 exp=0"); end
        if (first_av_k != -1)      begin n_fail++; $display("FAIL zero_arvalid got_k=%0d exp=none", first_av_k); end
        if (ar_addr_q.size() != 0) begin n_fail++; $display("FAIL zero_ar_count got=%0d exp=0", ar_addr_q.size()); end
        if (done_k != 2)           begin n_fail++; $display("FAIL zero_done_k got=%0d exp=2", done_k); end
        if (done_cnt != 1)         begin n_fail++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
        if (busy_cycles != 2)      begin n_fail++; $display("FAIL zero_busy got=%0d exp=2", busy_cycles); end
    endtask

    task automatic test_error();
        logic [31:0] exp_perf;
        run_job(64'h40000, 8, 4, 100, 100, 100, 0, 1'b0);
`ifdef SORT_RD_DMA_PERF_CNT_EN
        exp_perf = 32'(busy_cycles);
`else
        exp_perf = 32'd0;
`endif
        n_cmp += 4;
        if (timeout)              begin n_fail++; $display("FAIL err_timeout got=1 exp=0"); end
        if (err_after !== 1'b1)   begin n_fail++; $display("FAIL err_flag got=%b exp=1", err_after); end
        if (perf_after !== exp_perf) begin n_fail++; $display("FAIL err_perf got=%0d exp=%0d", perf_after, exp_perf); end
        if (out_q.size() != 8)    begin n_fail++; $display("FAIL err_out_count got=%0d exp=8", out_q.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (out_q[i] !== mk_data(64'h40000 + 64'(64 * i)))
                begin n_fail++; $display("FAIL err_data[%0d] got=%h exp=%h", i, out_q[i], mk_data(64'h40000 + 64'(64 * i))); end
        end
        run_job(64'h50000, 4, -1, 100, 100, 100, 0, 1'b0);
        n_cmp += 2;
        if (err_k1 !== 1'b0)    begin n_fail++; $display("FAIL err_clear_on_start got=%b exp=0", err_k1); end
        if (err_after !== 1'b0) begin n_fail++; $display("FAIL err_clean_job got=%b exp=0", err_after); end
    endtask

    task automatic test_random();
        logic [63:0] a;
        int beats, nb;
        logic [31:0] exp_perf;
        for (int t = 0; t < 5; t++) begin
            a = {46'd0, 12'($urandom_range(4095)), 6'd0};
            beats = int'($urandom_range(1, 200));
            build_exp(a, beats);
            run_job(a, beats, -1, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                    int'($urandom_range(30, 100)), 0, 1'b0);
`ifdef SORT_RD_DMA_PERF_CNT_EN
            exp_perf = 32'(busy_cycles);
`else
            exp_perf = 32'd0;
`endif
            n_cmp += 5;
            if (timeout)       begin n_fail++; $display("FAIL rnd%0d_timeout got=1 exp=0", t); end
            if (done_cnt != 1) begin n_fail++; $display("FAIL rnd%0d_done_cnt got=%0d exp=1", t, done_cnt); end
            if (max_res > 128) begin n_fail++; $display("FAIL rnd%0d_max_reserved got=%0d exp<=128", t, max_res); end
            if (perf_after !== exp_perf) begin n_fail++; $display("FAIL rnd%0d_perf got=%0d exp=%0d", t, perf_after, exp_perf); end
            if (ar_addr_q.size() != exp_addr_q.size())
                begin n_fail++; $display("FAIL rnd%0d_ar_count got=%0d exp=%0d", t, ar_addr_q.size(), exp_addr_q.size()); end
            else for (int i = 0; i < ar_addr_q.size(); i++) begin
                n_cmp++;
                if (ar_addr_q[i] !== exp_addr_q[i] || ar_len_q[i] != exp_len_q[i] - 1)
                    begin n_fail++; $display("FAIL rnd%0d_ar[%0d] got=%h/%0d exp=%h/%0d", t, i, ar_addr_q[i], ar_len_q[i], exp_addr_q[i], exp_len_q[i] - 1); end
            end
            nb = out_q.size();
            n_cmp++;
            if (nb != beats) begin n_fail++; $display("FAIL rnd%0d_out_count got=%0d exp=%0d", t, nb, beats); end
            else for (int i = 0; i < nb; i++) begin
                n_cmp++;
                if (out_q[i] !== mk_data(a + 64'(64 * i)))
                    begin n_fail++; $display("FAIL rnd%0d_data[%0d] got=%h exp=%h", t, i, out_q[i], mk_data(a + 64'(64 * i))); end
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        i_start = 1'b1; i_src_addr = 64'h9000; i_total_beats = 32'd40;
        @(negedge clk);
        i_start = 1'b0; arready = 1'b1; rvalid = 1'b0; i_ready = 1'b0;
        repeat (3) @(negedge clk);
        arready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp += 3;
        if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
        if (arvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_arvalid got=%b exp=0", arvalid); end
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_o_valid got=%b exp=0", o_valid); end
        run_job(64'hA000, 20, -1, 80, 80, 80, 0, 1'b0);
        n_cmp += 2;
        if (done_cnt != 1)      begin n_fail++; $display("FAIL midrst_job_done got=%0d exp=1", done_cnt); end
        if (out_q.size() != 20) begin n_fail++; $display("FAIL midrst_job_outs got=%0d exp=20", out_q.size()); end
    endtask

    initial begin
        salt = $urandom;
        rst = 1'b1; i_start = 1'b0; i_src_addr = '0; i_total_beats = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        i_ready = 1'b0;
        test_reset();
        test_single_burst();
        test_boundary();
        test_backpressure();
        test_zero_beats();
        test_error();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
